hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32I core; produces the `stall` input consumed by `control_unit` and the PC/IF-ID write enables.
- Keeps shadow copies of the destination-register info for the EX and MEM stages, built from the ID-stage control outputs.
- Detects load-use (and, optionally, all RAW) hazards, inserts bubbles, and squashes wrong-path instructions on a taken branch.
- Includes a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, width of register specifiers.
- CNT_W, 16, width of stall performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs1  in  REG_ADDR_W  source register 1 of ID instruction.
- id_rs2  in  REG_ADDR_W  source register 2 of ID instruction.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_rd  in  REG_ADDR_W  destination register of ID instruction.
- id_RegWrite  in  1  RegWrite from control_unit, already zeroed when stalled.
- id_MemRead  in  1  MemRead from control_unit, already zeroed when stalled.
- ex_branch_taken  in  1  branch/JAL resolved taken in EX this cycle.
- stall  out  1  hazard bubble request to control_unit.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register update enable.
- flush_if_id  out  1  clear IF/ID to a NOP.
- flush_id_ex  out  1  clear ID/EX to a NOP.
- stall_cycles  out  CNT_W  count of cycles with stall=1, saturating.

Behaviour:
- Shadow state, updated each clk:
  - EX shadow is {ex_valid, ex_rd, ex_RegWrite, ex_MemRead}.
  - MEM shadow is {mem_valid, mem_rd, mem_RegWrite}.
  - MEM shadow loads from EX shadow every cycle.
  - EX shadow loads {id_valid, id_rd, id_RegWrite, id_MemRead} unless stall=1 or ex_branch_taken=1; in those cases it loads a bubble (all fields 0).
- Reset:
  - All shadow fields clear to 0 and stall_cycles clears to 0.
  - While rst=1, outputs are forced: stall=0, pc_write=1, if_id_write=1, flush_if_id=0, flush_id_ex=0.
- match(r) is true when r != 0 and the ID instruction reads r:
  - (id_uses_rs1 and id_rs1==r) or (id_uses_rs2 and id_rs2==r).
  - Register x0 never creates a hazard.
- Load-use hazard: id_valid and ex_valid and ex_MemRead and ex_RegWrite and match(ex_rd).
- Outputs are combinational, with zero-cycle latency from inputs and shadow state:
  - stall = hazard and not ex_branch_taken.
  - pc_write = not stall.
  - if_id_write = not stall.
  - flush_if_id = ex_branch_taken.
  - flush_id_ex = ex_branch_taken.
- Simultaneous events: a taken branch has priority over a hazard. The ID instruction is wrong-path, so stall=0, the PC advances to the target, and both flushes assert.
- Load-use sequence:
  - Exactly one bubble cycle.
  - The next cycle the EX shadow holds a bubble, so the hazard clears.
  - The dependent instruction then proceeds and is served by the forwarding path from MEM/WB.
- Back-to-back hazards:
  - Each new load-use pair produces its own single-cycle stall.
  - A stall cycle never repeats for the same ID instruction unless the optional feature is enabled.
- stall_cycles:
  - Increments by 1 each cycle with stall=1.
  - Holds at all-ones with no wrap-around.
- Reset mid-stall: stall drops in the reset cycle, and shadows clear on that edge.

Optional Feature:
- Macro: HAZARD_NOFWD_EN, for builds without the forwarding unit.
- Defined:
  - hazard additionally includes (id_valid and ex_valid and ex_RegWrite and match(ex_rd)) or (id_valid and mem_valid and mem_RegWrite and match(mem_rd)).
  - A dependent instruction can therefore stall up to 2 consecutive cycles: 2 when the producer is in EX, 1 when it is in MEM.
  - Write-back is assumed to write the register file in the first half-cycle, so no WB-stage check is needed.
- Undefined: load-use check only, as specified above.

Test Plan:
- Reset: hold rst=1 for 3 cycles with hazard-producing inputs applied -> stall=0, pc_write=1, stall_cycles=0; all shadows empty after release.
- Load-use: `lw x5` (id_MemRead=1, id_RegWrite=1, id_rd=5) followed by `add x6,x5,x7` (id_rs1=5, uses_rs1=1) -> stall=1, pc_write=0, if_id_write=0 for exactly 1 cycle; stall_cycles=1.
- x0 and non-use: `lw x0` followed by a reader of x0, and `lw x5` followed by an instruction with uses_rs1=uses_rs2=0 -> stall stays 0 throughout.
- Branch priority: load-use condition present while ex_branch_taken=1 -> stall=0, flush_if_id=1, flush_id_ex=1, pc_write=1; the EX shadow next cycle is a bubble.
- Saturation: force 2^CNT_W+5 stall cycles (CNT_W=4 build, 21 stalls) -> stall_cycles=15 and holds.
- HAZARD_NOFWD_EN: `add x5` followed immediately by `sub x6,x5,x1` -> stall high for 2 cycles; with one independent instruction between them -> 1 cycle; feature undefined -> 0 cycles.

Source files
------------

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use hazard detection, branch squash and stall counter for the 5-stage RV32I pipeline
// Optional macro HAZARD_NOFWD_EN: stall on every RAW hazard against EX and MEM (no forwarding unit).
module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_RegWrite,
    input  logic                  id_MemRead,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_RegWrite;
    logic                  ex_MemRead;
    logic                  match_ex;
    logic                  hazard;
    logic                  squash_ex;

    // x0 is hardwired to zero, so it can never carry a dependency
    assign match_ex = (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

`ifdef HAZARD_NOFWD_EN
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_RegWrite;
    logic                  match_mem;

    assign match_mem = (mem_rd != '0) &&
                       ((id_uses_rs1 && (id_rs1 == mem_rd)) ||
                        (id_uses_rs2 && (id_rs2 == mem_rd)));

    assign hazard = id_valid &&
                    ((ex_valid && ex_RegWrite && match_ex) ||
                     (mem_valid && mem_RegWrite && match_mem));

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid    <= 1'b0;
            mem_rd       <= '0;
            mem_RegWrite <= 1'b0;
        end else begin
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_RegWrite <= ex_RegWrite;
        end
    end
`else
    assign hazard = id_valid && ex_valid && ex_MemRead && ex_RegWrite && match_ex;
`endif

    // A taken branch makes the ID instruction wrong-path, so it wins over any hazard
    assign stall       = !rst && hazard && !ex_branch_taken;
    assign pc_write    = !stall;
    assign if_id_write = !stall;
    assign flush_if_id = !rst && ex_branch_taken;
    assign flush_id_ex = !rst && ex_branch_taken;
    assign squash_ex   = stall || ex_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_rd       <= '0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
        end else if (squash_ex) begin
            ex_valid    <= 1'b0;
            ex_rd       <= '0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_rd       <= id_rd;
            ex_RegWrite <= id_RegWrite;
            ex_MemRead  <= id_MemRead;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

endmodule
